frv_fetch_prefetch: RTL

//  Parametrised instruction prefetch unit; next-generation fetch front end.
//  - Keeps up to MAX_REQS word fetches in flight on the imem bus.
//  - Queues in-order responses in a QUEUE_DEPTH-word FIFO feeding the fetch buffer/decode.
//  - Discards stale responses after a control-flow change using a drop counter.

---
 rtl/frv_fetch_prefetch_pkg.sv | 20 ++
 rtl/frv_fetch_prefetch_queue.sv | 57 +++++
 rtl/frv_fetch_prefetch.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/frv_fetch_prefetch_pkg.sv
// Shared definitions for the instruction prefetch unit.
// - XL               : machine word width
// - PC_RESET_DEFAULT : default fetch address after reset
// - fetch_entry_t    : one response FIFO entry {data, addr, half, err}
// - ENTRY_W          : packed width of fetch_entry_t
package frv_fetch_prefetch_pkg;

  localparam int unsigned XL = 32;
  localparam logic [XL-1:0] PC_RESET_DEFAULT = 32'h8000_0000;

  typedef struct packed {
    logic [XL-1:0] data;
    logic [XL-1:0] addr;
    logic          half;
    logic          err;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/frv_fetch_prefetch_queue.sv
// Synchronous response FIFO for the prefetch unit.
// Ports:
//   g_clk, g_resetn : clock, synchronous active-low reset
//   flush           : empty the FIFO; takes priority over push and pop
//   push, wdata     : write one entry
//   pop             : drop the head entry (ignored when empty)
//   rdata           : head entry
//   empty, full     : status flags
//   occupancy       : number of stored entries
module frv_fetch_prefetch_queue
  import frv_fetch_prefetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     g_clk,
  input  logic                     g_resetn,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [ENTRY_W-1:0]       wdata,
  output logic [ENTRY_W-1:0]       rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW:0]        wr_ptr_q, rd_ptr_q;
  logic               push_en, pop_en;

  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    occupancy = wr_ptr_q - rd_ptr_q;
    pop_en    = pop & ~empty;
    // A pop in the same cycle frees the slot, so push at full is legal then.
    push_en   = push & (~full | pop_en);
    rdata     = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge g_clk) begin
    if (push_en && !flush) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/frv_fetch_prefetch.sv
// Instruction prefetch unit: keeps up to MAX_REQS word fetches in flight,
// queues in-order responses for decode and drops stale responses after a
// control-flow change.
// Ports:
//   g_clk, g_resetn        : clock, synchronous active-low reset
//   cf_req/cf_target/cf_ack: control-flow change handshake
//   imem_*                 : instruction memory request/response bus
//   out_*                  : queue head {data, addr, half, error} with valid/ready
// Build option: FRV_FETCH_ERR_HALT_EN - a queued bus error halts issue until
// the next accepted control-flow change.
module frv_fetch_prefetch
  import frv_fetch_prefetch_pkg::*;
#(
  parameter logic [31:0] FRV_PC_RESET_VALUE = PC_RESET_DEFAULT,
  parameter int unsigned MAX_REQS           = 2,
  parameter int unsigned QUEUE_DEPTH        = 4
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        cf_req,
  input  logic [31:0] cf_target,
  output logic        cf_ack,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_recv,
  output logic        imem_ack,
  input  logic        imem_error,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [31:0] out_addr,
  output logic        out_half,
  output logic        out_error
);

  localparam int unsigned CW = $clog2(MAX_REQS + 1) + 1;
  localparam int unsigned QW = $clog2(QUEUE_DEPTH) + 1;

  logic          imem_req_q, imem_req_d;
  logic [31:0]   imem_addr_q, imem_addr_d;
  logic [31:0]   resp_addr_q, resp_addr_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] ignore_q, ignore_d;
  logic          halted_q, halted_d;
  logic          misaligned_q, misaligned_d;

  logic          grant, cf_accept, drop, push, pop;
  logic [QW-1:0] occupancy, occupancy_next;
  logic          q_empty;
  fetch_entry_t  push_entry, head;
  logic [ENTRY_W-1:0] q_rdata;
  logic          unused_q_full;
  logic          unused_cf_lsb;

  assign unused_cf_lsb = cf_target[0];

  assign cf_ack   = !imem_req_q || imem_gnt;
  assign imem_req = imem_req_q;
  assign imem_addr = imem_addr_q;
  // Queue space is reserved at issue time, so responses are always accepted.
  assign imem_ack = 1'b1;

  always_comb begin
    grant     = imem_req_q & imem_gnt;
    cf_accept = cf_req & cf_ack;
    drop      = imem_recv & (ignore_q != '0);
    push      = imem_recv & ~drop;
    pop       = out_ready & ~q_empty;

    outstanding_d = outstanding_q + CW'(grant) - CW'(imem_recv);

    if (cf_accept) occupancy_next = '0;
    else           occupancy_next = occupancy + QW'(push) - QW'(pop);

    imem_req_d = (imem_req_q & ~imem_gnt) |
                 (~halted_q && (32'(outstanding_d) < MAX_REQS) &&
                  (32'(outstanding_d) + 32'(occupancy_next) < QUEUE_DEPTH));

    imem_addr_d = imem_addr_q;
    if (cf_accept)  imem_addr_d = {cf_target[31:2], 2'b00};
    else if (grant) imem_addr_d = imem_addr_q + 32'd4;

    resp_addr_d = resp_addr_q;
    if (cf_accept) resp_addr_d = {cf_target[31:2], 2'b00};
    else if (push) resp_addr_d = resp_addr_q + 32'd4;

    // Every response still in flight at the change belongs to the old stream.
    ignore_d = ignore_q;
    if (cf_accept) ignore_d = outstanding_d;
    else if (drop) ignore_d = ignore_q - 1'b1;

    misaligned_d = misaligned_q;
    if (cf_accept) misaligned_d = cf_target[1];
    else if (push) misaligned_d = 1'b0;

`ifdef FRV_FETCH_ERR_HALT_EN
    halted_d = cf_accept ? 1'b0 : (halted_q | (push & imem_error));
`else
    halted_d = 1'b0;
`endif

    push_entry.data = imem_rdata;
    push_entry.addr = resp_addr_q;
    push_entry.half = misaligned_q;
    push_entry.err  = imem_error;
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      imem_req_q    <= 1'b0;
      imem_addr_q   <= FRV_PC_RESET_VALUE;
      resp_addr_q   <= FRV_PC_RESET_VALUE;
      outstanding_q <= '0;
      ignore_q      <= '0;
      halted_q      <= 1'b0;
      misaligned_q  <= 1'b0;
    end else begin
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
      resp_addr_q   <= resp_addr_d;
      outstanding_q <= outstanding_d;
      ignore_q      <= ignore_d;
      halted_q      <= halted_d;
      misaligned_q  <= misaligned_d;
    end
  end

  frv_fetch_prefetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .flush     (cf_accept),
    .push      (push),
    .pop       (pop),
    .wdata     (push_entry),
    .rdata     (q_rdata),
    .empty     (q_empty),
    .full      (unused_q_full),
    .occupancy (occupancy)
  );

  assign head      = fetch_entry_t'(q_rdata);
  assign out_valid = ~q_empty;
  assign out_data  = head.data;
  assign out_addr  = head.addr;
  assign out_half  = head.half;
  assign out_error = head.err;

endmodule
